// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is combinational from registered state; ID-stage resolution trains entries.
module branch_target_predictor #(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lk_en,
    input  logic [31:0] lk_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_next_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic        upd_jump,
    input  logic [31:0] upd_target,
    input  logic        upd_mispred,
    input  logic        inv_all,
    output logic [31:0] lk_cnt,
    output logic [31:0] mp_cnt
);

    localparam int TAG_W = 32 - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [CNT_W-1:0]   cnt_q    [ENTRIES];
    logic [CNT_W-1:0]   cnt_d    [ENTRIES];
    logic [31:0]        lk_cnt_q, lk_cnt_d;
    logic [31:0]        mp_cnt_q, mp_cnt_d;

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic             upd_hit;
    logic             unused_pc_bits;

    assign lk_idx  = lk_pc[IDX_W+1:2];
    assign lk_tag  = lk_pc[31:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[31:IDX_W+2];
    // Byte offset within the instruction word never affects index or tag.
    assign unused_pc_bits = ^{lk_pc[1:0], upd_pc[1:0]};

    // No bypass from the update port: lookup sees only registered state.
    assign pred_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken   = pred_hit && cnt_q[lk_idx][CNT_W-1];
    assign pred_next_pc = pred_taken ? target_q[lk_idx] : (lk_pc + 32'd4);

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        if (inv_all) begin
            valid_d = '0;
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_jump) begin
                    cnt_d[upd_idx] = CNT_MAX;
                end else if (upd_taken) begin
                    if (cnt_q[upd_idx] != CNT_MAX)
                        cnt_d[upd_idx] = cnt_q[upd_idx] + CNT_ONE;
                end else if (cnt_q[upd_idx] != '0) begin
                    cnt_d[upd_idx] = cnt_q[upd_idx] - CNT_ONE;
                end
                if (upd_taken)
                    target_d[upd_idx] = upd_target;
            end else if (upd_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target;
                cnt_d[upd_idx]    = upd_jump ? CNT_MAX : CNT_WEAK;
            end
        end
    end

    always_comb begin
        lk_cnt_d = lk_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (lk_en)
            lk_cnt_d = lk_cnt_q + 32'd1;
        if (upd_valid && upd_mispred)
            mp_cnt_d = mp_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            lk_cnt_q <= '0;
            mp_cnt_q <= '0;
            for (int k = 0; k < ENTRIES; k++) begin
                tag_q[k]    <= '0;
                target_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            lk_cnt_q <= lk_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign lk_cnt = lk_cnt_q;
    assign mp_cnt = mp_cnt_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor (ENTRIES=16, CNT_W=2) with a lookup scoreboard.
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        rst, lk_en, upd_valid, upd_taken, upd_jump, upd_mispred, inv_all;
    logic [31:0] lk_pc, upd_pc, upd_target;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_next_pc, lk_cnt, mp_cnt;

    typedef struct {
        string       name;
        logic        hit;
        logic        taken;
        logic [31:0] nxt;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   n_fail = 0;

    branch_target_predictor #(.ENTRIES(16), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .lk_en(lk_en), .lk_pc(lk_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_jump(upd_jump), .upd_target(upd_target), .upd_mispred(upd_mispred),
        .inv_all(inv_all), .lk_cnt(lk_cnt), .mp_cnt(mp_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp_v);
        end
    endtask

    // Drive lk_pc now, queue the expectation, then pop and compare once settled.
    task automatic look_now(input string name, input logic [31:0] pc,
                            input logic h, input logic t, input logic [31:0] n);
        exp_t e;
        lk_pc = pc;
        sb_q.push_back('{name, h, t, n});
        #1;
        e = sb_q.pop_front();
        chk({e.name, ".hit"},   {31'd0, pred_hit},   {31'd0, e.hit});
        chk({e.name, ".taken"}, {31'd0, pred_taken}, {31'd0, e.taken});
        chk({e.name, ".next"},  pred_next_pc,        e.nxt);
    endtask

    task automatic lookup(input string name, input logic [31:0] pc,
                          input logic h, input logic t, input logic [31:0] n);
        @(negedge clk);
        look_now(name, pc, h, t, n);
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic jp,
                       input logic [31:0] tgt, input logic inv);
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_jump = jp;
        upd_target = tgt; inv_all = inv;
        @(negedge clk);
        upd_valid = 1'b0; upd_taken = 1'b0; upd_jump = 1'b0; inv_all = 1'b0;
    endtask

    initial begin
        rst = 1'b1; lk_en = 1'b1; lk_pc = 32'h40;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_jump = 1'b0;
        upd_target = '0; upd_mispred = 1'b0; inv_all = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0; lk_en = 1'b0;

        look_now("rst_lk40", 32'h40, 1'b0, 1'b0, 32'h44);
        chk("rst_lk_cnt", lk_cnt, 32'd0);
        chk("rst_mp_cnt", mp_cnt, 32'd0);

        upd(32'h10, 1'b1, 1'b0, 32'h40, 1'b0);
        lookup("alloc_10", 32'h10, 1'b1, 1'b1, 32'h40);
        chk("alloc_cnt", {30'd0, dut.cnt_q[4]}, 32'd2);

        upd(32'h10, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("dec_cnt1", {30'd0, dut.cnt_q[4]}, 32'd1);
        upd(32'h10, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("dec_cnt0", {30'd0, dut.cnt_q[4]}, 32'd0);
        upd(32'h10, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("dec_sat0", {30'd0, dut.cnt_q[4]}, 32'd0);
        lookup("nt_10", 32'h10, 1'b1, 1'b0, 32'h14);

        upd(32'h50, 1'b1, 1'b0, 32'h80, 1'b0);
        lookup("alias_10", 32'h10, 1'b0, 1'b0, 32'h14);
        lookup("alias_50", 32'h50, 1'b1, 1'b1, 32'h80);

        // Update and lookup of the same entry in one cycle: no bypass.
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = 32'h20; upd_taken = 1'b1; upd_jump = 1'b1;
        upd_target = 32'h100;
        look_now("nobypass_20", 32'h20, 1'b0, 1'b0, 32'h24);
        @(negedge clk);
        upd_valid = 1'b0; upd_taken = 1'b0; upd_jump = 1'b0;
        look_now("jump_20", 32'h20, 1'b1, 1'b1, 32'h100);
        chk("jump_cnt", {30'd0, dut.cnt_q[8]}, 32'd3);

        @(negedge clk);
        lk_en = 1'b1;
        repeat (3) @(negedge clk);
        lk_en = 1'b0;
        chk("lk_cnt3", lk_cnt, 32'd3);

        // Two valid mispredicts, then mispred without upd_valid (not counted).
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = 32'h20; upd_taken = 1'b0; upd_jump = 1'b0; upd_mispred = 1'b1;
        repeat (2) @(negedge clk);
        upd_valid = 1'b0;
        @(negedge clk);
        upd_mispred = 1'b0;
        chk("mp_cnt2", mp_cnt, 32'd2);
        chk("nt_cnt_20", {30'd0, dut.cnt_q[8]}, 32'd1);
        lookup("weak_nt_20", 32'h20, 1'b1, 1'b0, 32'h24);

        upd(32'h30, 1'b1, 1'b0, 32'h200, 1'b1);
        lookup("inv_30", 32'h30, 1'b0, 1'b0, 32'h34);
        lookup("inv_20", 32'h20, 1'b0, 1'b0, 32'h24);
        lookup("inv_50", 32'h50, 1'b0, 1'b0, 32'h54);

        upd(32'h50, 1'b1, 1'b0, 32'h80, 1'b0);
        upd(32'h50, 1'b1, 1'b0, 32'h90, 1'b0);
        chk("inc_cnt", {30'd0, dut.cnt_q[4]}, 32'd3);
        lookup("lowbits_53", 32'h53, 1'b1, 1'b1, 32'h90);

        @(negedge clk);
        rst = 1'b1; lk_en = 1'b1; inv_all = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1; upd_target = 32'h300;
        @(negedge clk);
        rst = 1'b0; lk_en = 1'b0; inv_all = 1'b0; upd_valid = 1'b0; upd_taken = 1'b0;
        look_now("rst2_50", 32'h50, 1'b0, 1'b0, 32'h54);
        look_now("rst2_10", 32'h10, 1'b0, 1'b0, 32'h14);
        chk("rst2_lk_cnt", lk_cnt, 32'd0);
        chk("rst2_mp_cnt", mp_cnt, 32'd0);
        chk("rst2_cnt", {30'd0, dut.cnt_q[4]}, 32'd0);
        look_now("wrap_pc", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

        if (sb_q.size() != 0) begin
            n_total++;
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d leftover expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
